fp_align_ctrl: RTL and testbench

Sequenced exponent-compare and fraction-alignment controller for the floating-point adder. It accepts two operands (11-bit biased exponent plus 55-bit extended fraction) over a valid/ready handshake and orders them by magnitude. It drives one instance of the `lrs` logical right shifter to align the smaller fraction, folds the shifted-out bits into a sticky bit, and presents the aligned pair to the add/normalize stage over a second valid/ready handshake. It sits between operand unpack and the fraction adder.

---
 rtl/fp_align_ctrl.sv | 132 +++++++++++++
 tb/tb_fp_align_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_ctrl.sv
// Exponent-compare and fraction-alignment controller for the FP adder.
// Orders two operands by magnitude and right-aligns the smaller fraction with sticky.

module lrs #(
    parameter int FW = 55,
    parameter int SW = 7
) (
    input  logic [SW-1:0] as2,
    input  logic [FW-1:0] fb2,
    output logic [FW-1:0] fb3
);
    assign fb3 = fb2 >> as2;
endmodule

module fp_align_ctrl #(
    parameter int EW = 11,
    parameter int FW = 55,
    parameter int SW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW-1:0] ea,
    input  logic [EW-1:0] eb,
    input  logic [FW-1:0] fa,
    input  logic [FW-1:0] fb,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] e_big,
    output logic [FW-1:0] f_big,
    output logic [FW-1:0] f_small,
    output logic          sticky,
    output logic          swapped
);
    typedef enum logic [1:0] {IDLE, CMP, SHF, OUT} state_t;

    state_t        state;
    logic [EW-1:0] ea_q, eb_q, diff_q;
    logic [FW-1:0] fa_q, fb_q, f_sml_q;

    logic          a_big;
    logic          bypass;
    logic          sticky_n;
    logic [FW-1:0] shifted;
    logic [FW-1:0] mask;

    // A full tie (equal exponents and fractions) keeps operand a as the larger.
    assign a_big = (ea_q > eb_q) || ((ea_q == eb_q) && (fa_q >= fb_q));

    lrs #(.FW(FW), .SW(SW)) u_lrs (
        .as2 (diff_q[SW-1:0]),
        .fb2 (f_sml_q),
        .fb3 (shifted)
    );

    // Shifts of FW or more push every bit out, so the shifter is skipped and only the sticky survives.
    assign bypass   = (diff_q >= EW'(FW));
    assign mask     = ~({FW{1'b1}} << diff_q[SW-1:0]);
    assign sticky_n = bypass ? (|f_sml_q) : (|(f_sml_q & mask));

    // NOTE: every register here, datapath included, is reset so the outputs read 0 while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            ea_q      <= '0;
            eb_q      <= '0;
            fa_q      <= '0;
            fb_q      <= '0;
            diff_q    <= '0;
            f_sml_q   <= '0;
            e_big     <= '0;
            f_big     <= '0;
            f_small   <= '0;
            sticky    <= 1'b0;
            swapped   <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ea_q     <= ea;
                        eb_q     <= eb;
                        fa_q     <= fa;
                        fb_q     <= fb;
                        in_ready <= 1'b0;
                        state    <= CMP;
                    end
                end
                CMP: begin
                    if (a_big) begin
                        e_big   <= ea_q;
                        f_big   <= fa_q;
                        f_sml_q <= fb_q;
                        diff_q  <= ea_q - eb_q;
                        swapped <= 1'b0;
                    end else begin
                        e_big   <= eb_q;
                        f_big   <= fb_q;
                        f_sml_q <= fa_q;
                        diff_q  <= eb_q - ea_q;
                        swapped <= 1'b1;
                    end
                    state <= SHF;
                end
                SHF: begin
                    f_small   <= (bypass ? '0 : shifted) | {{(FW-1){1'b0}}, sticky_n};
                    sticky    <= sticky_n;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_align_ctrl.sv
// Directed-vector and scoreboard bench for fp_align_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_fp_align_ctrl;
    localparam logic [54:0] ONES = {55{1'b1}};
    localparam logic [54:0] TOP  = 55'h40_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] ea = '0, eb = '0;
    logic [54:0] fa = '0, fb = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [10:0] e_big;
    logic [54:0] f_big, f_small;
    logic        sticky, swapped;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    fp_align_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ea(ea), .eb(eb), .fa(fa), .fb(fb),
        .out_valid(out_valid), .out_ready(out_ready),
        .e_big(e_big), .f_big(f_big), .f_small(f_small),
        .sticky(sticky), .swapped(swapped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [10:0] ea, eb;
        logic [54:0] fa, fb;
        logic [10:0] e_big;
        logic [54:0] f_big, f_small;
        logic        sticky, swapped;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [10:0] a_e, input logic [10:0] b_e,
                                input logic [54:0] a_f, input logic [54:0] b_f,
                                input logic [10:0] x_e, input logic [54:0] x_fb,
                                input logic [54:0] x_fs, input logic x_st, input logic x_sw);
        vec_t v;
        v.ea = a_e; v.eb = b_e; v.fa = a_f; v.fb = b_f;
        v.e_big = x_e; v.f_big = x_fb; v.f_small = x_fs; v.sticky = x_st; v.swapped = x_sw;
        return v;
    endfunction

    // Independent reference: bit-serial sticky collection over the shifted-out positions.
    function automatic vec_t model(input logic [10:0] a_e, input logic [10:0] b_e,
                                   input logic [54:0] a_f, input logic [54:0] b_f);
        vec_t v;
        logic [54:0] sm;
        int d;
        logic st;
        v.ea = a_e; v.eb = b_e; v.fa = a_f; v.fb = b_f;
        if (a_e > b_e || (a_e == b_e && a_f >= b_f)) begin
            v.e_big = a_e; v.f_big = a_f; sm = b_f; v.swapped = 1'b0; d = int'(a_e) - int'(b_e);
        end else begin
            v.e_big = b_e; v.f_big = b_f; sm = a_f; v.swapped = 1'b1; d = int'(b_e) - int'(a_e);
        end
        st = 1'b0;
        if (d >= 55) begin
            st = (sm != 0);
            v.f_small = 55'(st);
        end else begin
            for (int k = 0; k < d; k++) st = st | sm[k];
            v.f_small = sm >> d;
            v.f_small[0] = v.f_small[0] | st;
        end
        v.sticky = st;
        return v;
    endfunction

    task automatic wait_in_ready(input string name);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_in_ready_wait"}, 64'(in_ready), 64'd1);
    endtask

    task automatic check_outputs(input string name, input vec_t v);
        check({name, "_e_big"},   64'(e_big),   64'(v.e_big));
        check({name, "_f_big"},   64'(f_big),   64'(v.f_big));
        check({name, "_f_small"}, 64'(f_small), 64'(v.f_small));
        check({name, "_sticky"},  64'(sticky),  64'(v.sticky));
        check({name, "_swapped"}, 64'(swapped), 64'(v.swapped));
    endtask

    // Present a pair, verify the 2-cycle latency, the result, and the return to IDLE.
    task automatic do_txn(input string name, input vec_t v);
        wait_in_ready(name);
        ea = v.ea; eb = v.eb; fa = v.fa; fb = v.fb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_busy"}, 64'(in_ready), 64'd0);
        @(negedge clk);
        check({name, "_early_valid"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check_outputs(name, v);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_done_valid"}, 64'(out_valid), 64'd0);
        check({name, "_done_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        vec_t v, v2;
        int last_acc;
        int n;

        vecs[0] = mk(11'd1023, 11'd1020, TOP, ONES, 11'd1023, TOP, 55'h0F_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        vecs[1] = mk(11'd1000, 11'd1005, TOP, TOP, 11'd1005, TOP, 55'h02_0000_0000_0000, 1'b0, 1'b1);
        vecs[2] = mk(11'd7, 11'd7, 55'd1, 55'd2, 11'd7, 55'd2, 55'd1, 1'b0, 1'b1);
        vecs[3] = mk(11'd1054, 11'd1000, TOP, ONES, 11'd1054, TOP, 55'd1, 1'b1, 1'b0);
        vecs[4] = mk(11'd1055, 11'd1000, TOP, ONES, 11'd1055, TOP, 55'd1, 1'b1, 1'b0);
        vecs[5] = mk(11'd1100, 11'd1000, TOP, 55'd0, 11'd1100, TOP, 55'd0, 1'b0, 1'b0);
        vecs[6] = mk(11'd500, 11'd500, 55'd123, 55'd123, 11'd500, 55'd123, 55'd123, 1'b0, 1'b0);
        vecs[7] = mk(11'd2000, 11'd10, TOP, 55'd5, 11'd2000, TOP, 55'd1, 1'b1, 1'b0);
        vecs[8] = mk(11'd3, 11'd5, 55'h7, 55'h1000, 11'd5, 55'h1000, 55'd1, 1'b1, 1'b1);
        vecs[9] = mk(11'd20, 11'd20, 55'd9, 55'd4, 11'd20, 55'd9, 55'd4, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        v = mk('0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        check_outputs("rst", v);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) do_txn($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: second pair must wait until the first result is consumed.
        v = vecs[0];
        v2 = vecs[1];
        wait_in_ready("bp");
        ea = v.ea; eb = v.eb; fa = v.fa; fb = v.fb; in_valid = 1'b1;
        @(negedge clk);
        ea = v2.ea; eb = v2.eb; fa = v2.fa; fb = v2.fb;
        repeat (2) @(negedge clk);
        check("bp_valid", 64'(out_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("bp_hold%0d_ready", k), 64'(in_ready), 64'd0);
            check($sformatf("bp_hold%0d_f_small", k), 64'(f_small), 64'(v.f_small));
            check($sformatf("bp_hold%0d_e_big", k), 64'(e_big), 64'(v.e_big));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        check("bp_release_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_accept", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        check("bp_second_valid", 64'(out_valid), 64'd1);
        check_outputs("bp_second", v2);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset while in SHF
        v = vecs[0];
        wait_in_ready("rsh");
        ea = v.ea; eb = v.eb; fa = v.fa; fb = v.fb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rsh_valid", 64'(out_valid), 64'd0);
        check("rsh_ready", 64'(in_ready), 64'd1);
        v2 = mk('0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        check_outputs("rsh", v2);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Flush in CMP: transaction dropped, no out_valid pulse.
        v = vecs[2];
        wait_in_ready("fcmp");
        ea = v.ea; eb = v.eb; fa = v.fa; fb = v.fb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fcmp_ready", 64'(in_ready), 64'd1);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("fcmp_no_valid", 64'(n), 64'd0);

        // Flush together with out_ready in OUT: back to IDLE, data held.
        v = vecs[3];
        wait_in_ready("fout");
        ea = v.ea; eb = v.eb; fa = v.fa; fb = v.fb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("fout_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b0;
        check("fout_ready", 64'(in_ready), 64'd1);
        check("fout_cleared", 64'(out_valid), 64'd0);
        check("fout_held", 64'(f_small), 64'(v.f_small));

        // Back-to-back random pairs with out_ready held high.
        out_ready = 1'b1;
        last_acc = -1;
        for (int i = 0; i < 10; i++) begin
            logic [10:0] ra, rb;
            logic [54:0] xa, xb;
            ra = 11'($urandom_range(100, 1900));
            rb = 11'(int'(ra) + int'($urandom_range(0, 70)) - 30);
            xa = 55'({$urandom, $urandom});
            xb = 55'({$urandom, $urandom});
            if (i == 3) rb = ra;
            v = model(ra, rb, xa, xb);
            ea = ra; eb = rb; fa = xa; fb = xb; in_valid = 1'b1;
            wait_in_ready($sformatf("rnd%0d", i));
            if (last_acc >= 0) check($sformatf("rnd%0d_interval", i), 64'(cyc - last_acc), 64'd4);
            last_acc = cyc;
            @(negedge clk);
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("rnd%0d_latency", i), 64'(n), 64'd2);
            check_outputs($sformatf("rnd%0d", i), v);
        end
        out_ready = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
